// File: rtl/mlp_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : mlp_pkg
//  Description : Shared constants and types for the MLP stream router.
//                Optional build macro used by the router: MLP_TLAST_CHECK_EN
//  Revision    : 1.0  initial release
// ============================================================================
package mlp_pkg;

    localparam int DATA_W     = 18;
    localparam int AXIS_W     = 32;
    localparam int IMG_LEN    = 784;
    localparam int L1_NEURONS = 30;
    localparam int L1_IN_LEN  = 784;
    localparam int L2_NEURONS = 10;
    localparam int L2_IN_LEN  = 784;

    // Record counter and neuron index widths
    localparam int CNT_W = 10;
    localparam int IDX_W = 5;

    typedef logic [DATA_W-1:0] word_t;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        IMG  = 3'd1,
        WGT  = 3'd2,
        BIAS = 3'd3,
        FIN  = 3'd4
    } router_state_t;

endpackage
`default_nettype wire

// File: rtl/mlp_stream_router.sv
`default_nettype none
// ============================================================================
//  Module      : mlp_stream_router
//  Description : Parses the per-image AXI-Stream (pixels, then hidden-layer
//                weights/biases, then output-layer weights/biases). Pixels
//                are written to the image buffer; weights and biases are
//                passed straight through to the MAC core with layer/neuron
//                tags.
//                Build macro MLP_TLAST_CHECK_EN enables the sticky tlast
//                framing check on the err port; otherwise err is tied low.
//  Revision    : 1.0  initial release
// ============================================================================
module mlp_stream_router #(
    parameter int DATA_W     = mlp_pkg::DATA_W,
    parameter int AXIS_W     = mlp_pkg::AXIS_W,
    parameter int IMG_LEN    = mlp_pkg::IMG_LEN,
    parameter int L1_NEURONS = mlp_pkg::L1_NEURONS,
    parameter int L1_IN_LEN  = mlp_pkg::L1_IN_LEN,
    parameter int L2_NEURONS = mlp_pkg::L2_NEURONS,
    parameter int L2_IN_LEN  = mlp_pkg::L2_IN_LEN
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [AXIS_W-1:0] s_axis_tdata,
    input  logic              s_axis_tvalid,
    input  logic              s_axis_tlast,
    output logic              s_axis_tready,
    output logic              img_we,
    output logic [9:0]        img_addr,
    output logic [DATA_W-1:0] img_data,
    output logic [DATA_W-1:0] w_data,
    output logic              w_valid,
    input  logic              w_ready,
    output logic [DATA_W-1:0] b_data,
    output logic              b_valid,
    input  logic              b_ready,
    output logic              layer,
    output logic [4:0]        neuron_idx,
    output logic              busy,
    output logic              done,
    output logic              err
);
    import mlp_pkg::*;

    localparam logic [CNT_W-1:0] c_img_last   = CNT_W'(IMG_LEN - 1);
    localparam logic [CNT_W-1:0] c_l1_in_last = CNT_W'(L1_IN_LEN - 1);
    localparam logic [CNT_W-1:0] c_l2_in_last = CNT_W'(L2_IN_LEN - 1);
    localparam logic [IDX_W-1:0] c_l1_last    = IDX_W'(L1_NEURONS - 1);
    localparam logic [IDX_W-1:0] c_l2_last    = IDX_W'(L2_NEURONS - 1);

    router_state_t    r_state;
    router_state_t    w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_wgt_last;
    logic             w_go;
    logic             w_cnt_inc;
    logic             w_cnt_clr;
    logic             w_next_layer;
    logic             w_next_neuron;
    logic             w_pix_fire;

    assign busy       = (r_state != IDLE);
    assign w_wgt_last = layer ? c_l2_in_last : c_l1_in_last;
    assign w_pix_fire = (r_state == IMG) && s_axis_tvalid;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode and stream steering; weight/bias paths are pure pass-through
    always_comb begin
        w_state_next  = r_state;
        s_axis_tready = 1'b0;
        w_valid       = 1'b0;
        b_valid       = 1'b0;
        w_data        = '0;
        b_data        = '0;
        done          = 1'b0;
        w_go          = 1'b0;
        w_cnt_inc     = 1'b0;
        w_cnt_clr     = 1'b0;
        w_next_layer  = 1'b0;
        w_next_neuron = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_next = IMG;
                    w_go         = 1'b1;
                end
            end
            IMG: begin
                s_axis_tready = 1'b1;
                if (s_axis_tvalid) begin
                    if (r_cnt == c_img_last) begin
                        w_state_next = WGT;
                        w_cnt_clr    = 1'b1;
                    end else begin
                        w_cnt_inc = 1'b1;
                    end
                end
            end
            WGT: begin
                s_axis_tready = w_ready;
                w_valid       = s_axis_tvalid;
                w_data        = s_axis_tdata[DATA_W-1:0];
                if (s_axis_tvalid && w_ready) begin
                    if (r_cnt == w_wgt_last) begin
                        w_state_next = BIAS;
                        w_cnt_clr    = 1'b1;
                    end else begin
                        w_cnt_inc = 1'b1;
                    end
                end
            end
            BIAS: begin
                s_axis_tready = b_ready;
                b_valid       = s_axis_tvalid;
                b_data        = s_axis_tdata[DATA_W-1:0];
                if (s_axis_tvalid && b_ready) begin
                    if (!layer && (neuron_idx == c_l1_last)) begin
                        w_state_next = WGT;
                        w_next_layer = 1'b1;
                    end else if (layer && (neuron_idx == c_l2_last)) begin
                        w_state_next = FIN;
                    end else begin
                        w_state_next  = WGT;
                        w_next_neuron = 1'b1;
                    end
                end
            end
            FIN: begin
                done         = 1'b1;
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Word counter within the current record plus layer/neuron tags
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt      <= '0;
            layer      <= 1'b0;
            neuron_idx <= '0;
        end else begin
            if (w_go || w_cnt_clr) begin
                r_cnt <= '0;
            end else if (w_cnt_inc) begin
                r_cnt <= r_cnt + 10'd1;
            end
            if (w_go) begin
                layer      <= 1'b0;
                neuron_idx <= '0;
            end else if (w_next_layer) begin
                layer      <= 1'b1;
                neuron_idx <= '0;
            end else if (w_next_neuron) begin
                neuron_idx <= neuron_idx + 5'd1;
            end
        end
    end

    // Image buffer write port, one cycle behind the accepted pixel
    always_ff @(posedge clk) begin
        if (reset) begin
            img_we   <= 1'b0;
            img_addr <= '0;
            img_data <= '0;
        end else begin
            img_we <= w_pix_fire;
            if (w_pix_fire) begin
                img_addr <= r_cnt;
                img_data <= s_axis_tdata[DATA_W-1:0];
            end
        end
    end

`ifdef MLP_TLAST_CHECK_EN
    logic r_err;
    logic w_tlast_bad;

    // tlast must mark exactly the last pixel and every bias word
    always_comb begin
        w_tlast_bad = 1'b0;
        case (r_state)
            IMG:     if (s_axis_tvalid)            w_tlast_bad = (s_axis_tlast != (r_cnt == c_img_last));
            WGT:     if (s_axis_tvalid && w_ready) w_tlast_bad = s_axis_tlast;
            BIAS:    if (s_axis_tvalid && b_ready) w_tlast_bad = !s_axis_tlast;
            default: w_tlast_bad = 1'b0;
        endcase
    end

    // Sticky framing error, cleared by reset or an accepted start
    always_ff @(posedge clk) begin
        if (reset) begin
            r_err <= 1'b0;
        end else if (w_go) begin
            r_err <= 1'b0;
        end else if (w_tlast_bad) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;

    wire w_unused_bits = &{1'b0, s_axis_tdata[AXIS_W-1:DATA_W]};
`else
    assign err = 1'b0;

    wire w_unused_bits = &{1'b0, s_axis_tdata[AXIS_W-1:DATA_W], s_axis_tlast};
`endif

endmodule
`default_nettype wire

// File: doc/mlp_stream_router.md
Name: mlp_stream_router

Overview:
- Sits directly downstream of the AXI-Stream slave interface inside axi_mlp_v1_0 and feeds the MLP datapath.
- Parses the fixed per-image stream in order: 784 pixels, then 30 hidden neurons × (784 weights + 1 bias), then 10 output neurons × (L2_IN_LEN weights + 1 bias).
- Pixels are written into the image buffer; weights and biases go to the MAC core on handshaked ports, tagged with the current layer and neuron index.

Parameters:
- DATA_W, 18, fixed-point word width taken from tdata[DATA_W-1:0]
- AXIS_W, 32, AXI-Stream tdata width
- IMG_LEN, 784, pixels per image
- L1_NEURONS, 30, hidden-layer neurons
- L1_IN_LEN, 784, weights per hidden neuron
- L2_NEURONS, 10, output-layer neurons
- L2_IN_LEN, 784, weights per output neuron; the stream format pads to this length, and every word is forwarded

Ports:
- clk, in, 1, single clock for the block
- reset, in, 1, synchronous, active-high
- start, in, 1, one-cycle pulse from the START register
- s_axis_tdata, in, AXIS_W, stream data
- s_axis_tvalid, in, 1, stream valid
- s_axis_tlast, in, 1, stream last
- s_axis_tready, out, 1, stream ready
- img_we, out, 1, image buffer write enable
- img_addr, out, 10, image buffer address
- img_data, out, DATA_W, pixel
- w_data, out, DATA_W, weight to MAC
- w_valid, out, 1, weight valid
- w_ready, in, 1, MAC accepts weight
- b_data, out, DATA_W, bias to MAC
- b_valid, out, 1, bias valid; this also marks the end of the neuron
- b_ready, in, 1, MAC accepts bias
- layer, out, 1, 0 = hidden, 1 = output
- neuron_idx, out, 5, current neuron within the layer
- busy, out, 1, FSM not in IDLE
- done, out, 1, one-cycle pulse after the last bias is accepted
- err, out, 1, sticky protocol error (only when MLP_TLAST_CHECK_EN is defined)

Behaviour:
- Reset values:
  - FSM state is IDLE.
  - s_axis_tready, img_we, w_valid, b_valid, busy, done and err are 0.
  - All counters, layer and neuron_idx are 0.
  - img_addr and data outputs are 0.
  - Reset mid-operation aborts immediately, leaves partially written image contents as they are, and drops no handshake illegally.
- States: IDLE, IMG, WGT, BIAS, FIN.
- IDLE:
  - s_axis_tready = 0.
  - start moves to IMG and clears the pixel/weight counters, layer and neuron_idx.
  - start is ignored in every other state.
- IMG:
  - s_axis_tready = 1.
  - Each tvalid cycle registers img_we = 1, img_addr = pixel count and img_data = tdata[DATA_W-1:0]. Write latency is 1 cycle.
  - The IMG_LEN-th accepted word moves to WGT.
- WGT:
  - w_data and w_valid are combinational pass-through: w_valid = tvalid, and s_axis_tready = w_ready. There is no buffering.
  - A transfer is counted when tvalid && w_ready.
  - The transfer at count = IN_LEN(layer) − 1 moves to BIAS.
- BIAS:
  - b_valid = tvalid, and s_axis_tready = b_ready.
  - On transfer:
    - If neuron_idx is the last neuron of layer 0: set layer = 1, neuron_idx = 0, go to WGT.
    - If neuron_idx is the last neuron of layer 1: go to FIN.
    - Otherwise: neuron_idx++, go to WGT.
- FIN: pulse done for 1 cycle, then go to IDLE.
- Only the active state's output port asserts valid; w_valid and b_valid are never high together.
- tdata bits above DATA_W are ignored. No sign or width conversion is done; the bits pass through.
- Counters are 10 bits. They never wrap within a record; they clear on every state change.
- tlast is ignored unless MLP_TLAST_CHECK_EN is defined.

Optional Feature:
- Macro: MLP_TLAST_CHECK_EN.
- Defined:
  - tlast is required on the final word of each record: the last pixel, and every bias.
  - A mismatch (tlast missing at the boundary, or asserted elsewhere) sets err. err stays set until reset or the next start.
  - The transfer still completes and the FSM continues normally.
- Undefined: the err port is tied to 0, and tlast is unused.

Decomposition:
- Package mlp_pkg holds:
  - constants IMG_LEN, L1_NEURONS, L1_IN_LEN, L2_NEURONS, L2_IN_LEN and DATA_W;
  - the FSM enum type router_state_t (IDLE, IMG, WGT, BIAS, FIN);
  - subtype word_t, logic [DATA_W-1:0].
- No sub-module is needed. The counter and FSM logic stay in one file of about 200 lines.

Test Plan:
- Pixel load:
  - Stimulus: reset, start pulse, 784 words 0..783 with tvalid held high.
  - Expected: img_we on 784 consecutive cycles, img_addr 0..783, img_data equal to the word; then the FSM enters WGT; busy = 1.
- Full stream:
  - Stimulus: the full stream of 784 + 30×785 + 10×785 words, with w_ready and b_ready tied to 1.
  - Expected: exactly 31360 w_valid transfers and 40 b_valid transfers.
  - Expected: layer toggles after the 30th bias; neuron_idx sequence is 0..29 then 0..9; a single done pulse one cycle after the last bias.
- Backpressure:
  - Stimulus: w_ready low for 5 cycles in the middle of neuron 3.
  - Expected: s_axis_tready = 0 for those cycles, w_data stable, and no word lost or duplicated (checked with a scoreboard on the counts).
- Mid-stream reset:
  - Stimulus: reset asserted during neuron 12's weights.
  - Expected: all outputs return to their reset values next cycle; a new start followed by a full stream completes correctly.
- Start while busy:
  - Stimulus: start pulsed while busy.
  - Expected: no effect.
  - Stimulus: tdata = 0xFFFC0001.
  - Expected: output word = 18'h00001, because the upper bits are dropped.
- tlast check (MLP_TLAST_CHECK_EN defined):
  - Stimulus: tlast missing on the 5th bias.
  - Expected: err = 1 and sticky, the stream still completes, and err clears on the next start.
